hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Consumer end of the per-instruction hazard encoding (Tuse bits, register addresses, result class) produced in D.
- Keeps its own E/M/W scoreboard of pending writes with Tnew countdowns.
- Decides D-stage stall and all forwarding-mux selects for the 5-stage MIPS pipeline.
- Sits beside the datapath. Feeds the PC/IF-ID enable, the ID-EX bubble insert, and the D/E/M forwarding muxes.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter
- TNEW_ALU, 1, Tnew at E entry for ALU-class results
- TNEW_DM, 2, Tnew at E entry for DM-class results

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous reset, active-low (0 = reset)
- tuse_rs0  in  1  D instr reads rs in D (Tuse 0)
- tuse_rs1  in  1  D instr reads rs in E (Tuse 1)
- tuse_rt0  in  1  D instr reads rt in D (Tuse 0)
- tuse_rt1  in  1  D instr reads rt in E (Tuse 1)
- tuse_rt2  in  1  D instr reads rt in M (Tuse 2, store data)
- a1_d  in  5  rs of D instr
- a2_d  in  5  rt of D instr
- a3_d  in  5  destination of D instr (0 = none)
- res_d  in  2  result class: 00 none, 01 alu, 10 dm, 11 pc
- stall  out  1  freeze PC and IF/ID, bubble into ID/EX
- fwd_rs_d  out  2  D rs source: 00 GRF, 01 E, 10 M, 11 W
- fwd_rt_d  out  2  D rt source, same encoding
- fwd_rs_e  out  2  E rs source: 00 pipe reg, 10 M, 11 W
- fwd_rt_e  out  2  E rt source, same encoding
- fwd_rt_m  out  1  M store data: 0 pipe reg, 1 W
- stall_cnt  out  CNT_W  total stall cycles since reset

Behaviour:
- State per stage S in {E,M,W}: a1_S, a2_S, a3_S, tnew_S (2b).
- All outputs are combinational from state and D inputs, except stall_cnt, which is registered.
- Reset (reset=0 at an edge):
  - All state and stall_cnt are cleared.
  - Consequently stall=0 and all fwd selects are 0.
  - Reset asserted mid-stall clears everything at that edge; no residual stall.
- Tnew at E entry:
  - alu gives TNEW_ALU.
  - dm gives TNEW_DM.
  - pc and none give 0.
- Advance each edge:
  - tnew_M <= sat0(tnew_E-1).
  - tnew_W <= sat0(tnew_M-1).
  - a* fields shift E to M to W.
- Stall:
  - E loads the bubble (a1=a2=a3=0, tnew=0).
  - M and W still advance.
  - stall_cnt increments, saturating at all-ones.
- Tuse:
  - rs Tuse is 0 if tuse_rs0, else 1 if tuse_rs1, else unused.
  - rt Tuse is 0/1/2 by lowest set bit, else unused.
- Match condition: reg != 0 and a3_S == reg.
- Stall rule, evaluated for each used operand:
  - Find the first matching stage, searching E then M.
  - stall=1 if that stage's tnew > Tuse.
  - stall = OR over rs and rt.
  - A match in E shadows M.
- Forward select for D operands:
  - Priority E, M, W.
  - The first matching stage is chosen only if its tnew==0; otherwise 00.
  - The select is output even while stall=1.
- Forward select for E operands (reg = a1_E/a2_E):
  - Priority M, then W, with the same tnew==0 gate.
- fwd_rt_m is 1 iff a2_M matches a3_W.
- Register $0 never stalls or forwards.
- Unused operands still produce selects; this is harmless and the datapath ignores them.

Decomposition:
- Shared package (hazard_pkg) holds:
  - RES_NW/ALU/DM/PC class codes
  - FWD_GRF/E/M/W select codes
  - the 2-bit Tnew type
- One sub-module, fwd_pick: given reg and up to three (a3, tnew) candidates in priority order, returns the 2-bit select and a match_tnew value.
- fwd_pick is instantiated five times. The stall check reuses its match_tnew output.

Test Plan:
1. Hold reset=0 for 2 cycles with random inputs -> stall=0, all fwd=0, stall_cnt=0. Release -> outputs follow rules.
2. lw $1 (res=10, a3=1), then beq reading $1/$1 (rs0, rt0) -> stall=1 for 2 cycles. Third cycle: stall=0, fwd_rs_d=fwd_rt_d=11. stall_cnt=2.
3. addu $3, then addu rs=$3 (rs1) -> no stall. Next cycle fwd_rs_e=10. Cycle after that, with $3 in W and a consumer in E: fwd_rs_e=11.
4. jal (res=11, a3=31), then jr $31 (rs0) -> stall=0, fwd_rs_d=01 immediately.
5. lw $0, then beq $0 -> stall=0, fwd=00. Separately, lw $2, then sw rt=$2 (rt2) -> no stall; when sw is in M, fwd_rt_m=1.
6. Preload stall_cnt near saturation, or use CNT_W=2 with 5 lw/beq stalls -> stall_cnt holds at 3. Assert reset mid-stall -> stall=0 the next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared codes and types for the MIPS hazard controller.
// Result classes, forwarding selects and the Tnew countdown type.
package hazard_pkg;

    typedef logic [1:0] tnew_t;
    typedef logic [1:0] res_t;
    typedef logic [1:0] fwd_t;

    localparam res_t RES_NW  = 2'b00;
    localparam res_t RES_ALU = 2'b01;
    localparam res_t RES_DM  = 2'b10;
    localparam res_t RES_PC  = 2'b11;

    localparam fwd_t FWD_GRF = 2'b00;
    localparam fwd_t FWD_E   = 2'b01;
    localparam fwd_t FWD_M   = 2'b10;
    localparam fwd_t FWD_W   = 2'b11;

    function automatic tnew_t dec_sat(input tnew_t t);
        return (t == '0) ? '0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_pick.sv
// Picks the first pending writer of a register among three
// prioritised candidates; slot k maps to select code k+1.
module fwd_pick
    import hazard_pkg::*;
#(
    parameter logic [2:0] EN      = 3'b111,
    parameter logic [2:0] TNEW_EN = 3'b011
) (
    input  logic [4:0] i_reg,
    input  logic [4:0] i_a3_0,
    input  logic [4:0] i_a3_1,
    input  logic [4:0] i_a3_2,
    input  tnew_t      i_tnew_0,
    input  tnew_t      i_tnew_1,
    input  tnew_t      i_tnew_2,
    output fwd_t       o_sel,
    output tnew_t      o_match_tnew
);

    logic [2:0] w_hit;
    logic [2:0] w_first;

    assign w_hit[0] = EN[0] && (i_reg != '0) && (i_a3_0 == i_reg);
    assign w_hit[1] = EN[1] && (i_reg != '0) && (i_a3_1 == i_reg);
    assign w_hit[2] = EN[2] && (i_reg != '0) && (i_a3_2 == i_reg);

    // one-hot of the highest-priority hit, so the decoder is truly unique
    assign w_first[0] = w_hit[0];
    assign w_first[1] = w_hit[1] && !w_hit[0];
    assign w_first[2] = w_hit[2] && !w_hit[1] && !w_hit[0];

    always_comb begin
        o_sel        = FWD_GRF;
        o_match_tnew = '0;
        unique case (1'b1)
            w_first[0]: begin
                o_sel        = (i_tnew_0 == '0) ? FWD_E : FWD_GRF;
                o_match_tnew = TNEW_EN[0] ? i_tnew_0 : '0;
            end
            w_first[1]: begin
                o_sel        = (i_tnew_1 == '0) ? FWD_M : FWD_GRF;
                o_match_tnew = TNEW_EN[1] ? i_tnew_1 : '0;
            end
            w_first[2]: begin
                o_sel        = (i_tnew_2 == '0) ? FWD_W : FWD_GRF;
                o_match_tnew = TNEW_EN[2] ? i_tnew_2 : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// D-stage stall and forwarding control for the 5-stage MIPS pipe,
// tracking pending E/M/W writes with Tnew countdowns.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int TNEW_ALU = 1,
    parameter int TNEW_DM  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tuse_rs0,
    input  logic             tuse_rs1,
    input  logic             tuse_rt0,
    input  logic             tuse_rt1,
    input  logic             tuse_rt2,
    input  logic [4:0]       a1_d,
    input  logic [4:0]       a2_d,
    input  logic [4:0]       a3_d,
    input  logic [1:0]       res_d,
    output logic             stall,
    output logic [1:0]       fwd_rs_d,
    output logic [1:0]       fwd_rt_d,
    output logic [1:0]       fwd_rs_e,
    output logic [1:0]       fwd_rt_e,
    output logic             fwd_rt_m,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [4:0] r_a1_e, r_a2_e, r_a3_e;
    logic [4:0] r_a2_m, r_a3_m;
    logic [4:0] r_a3_w;
    tnew_t      r_tnew_e, r_tnew_m, r_tnew_w;
    logic [CNT_W-1:0] r_cnt;

    tnew_t w_tnew_d;
    tnew_t w_rs_tnew, w_rt_tnew;
    tnew_t w_rs_tuse, w_rt_tuse;
    logic  w_rs_used, w_rt_used;
    logic  w_stall;
    fwd_t  w_rt_m_sel;
    tnew_t w_rs_e_tnew_unused;
    tnew_t w_rt_e_tnew_unused;
    tnew_t w_rt_m_tnew_unused;

    always_comb begin
        w_tnew_d = '0;
        unique case (res_d)
            RES_ALU: w_tnew_d = tnew_t'(TNEW_ALU);
            RES_DM:  w_tnew_d = tnew_t'(TNEW_DM);
            default: w_tnew_d = '0;
        endcase
    end

    assign w_rs_used = tuse_rs0 | tuse_rs1;
    assign w_rs_tuse = tuse_rs0 ? 2'd0 : 2'd1;
    assign w_rt_used = tuse_rt0 | tuse_rt1 | tuse_rt2;
    assign w_rt_tuse = tuse_rt0 ? 2'd0 : (tuse_rt1 ? 2'd1 : 2'd2);

    // D operands: E, M, W; stall tnew only from E and M
    fwd_pick #(.EN(3'b111), .TNEW_EN(3'b011)) u_rs_d (
        .i_reg        (a1_d),
        .i_a3_0       (r_a3_e),
        .i_a3_1       (r_a3_m),
        .i_a3_2       (r_a3_w),
        .i_tnew_0     (r_tnew_e),
        .i_tnew_1     (r_tnew_m),
        .i_tnew_2     (r_tnew_w),
        .o_sel        (fwd_rs_d),
        .o_match_tnew (w_rs_tnew)
    );

    fwd_pick #(.EN(3'b111), .TNEW_EN(3'b011)) u_rt_d (
        .i_reg        (a2_d),
        .i_a3_0       (r_a3_e),
        .i_a3_1       (r_a3_m),
        .i_a3_2       (r_a3_w),
        .i_tnew_0     (r_tnew_e),
        .i_tnew_1     (r_tnew_m),
        .i_tnew_2     (r_tnew_w),
        .o_sel        (fwd_rt_d),
        .o_match_tnew (w_rt_tnew)
    );

    fwd_pick #(.EN(3'b110), .TNEW_EN(3'b000)) u_rs_e (
        .i_reg        (r_a1_e),
        .i_a3_0       (5'd0),
        .i_a3_1       (r_a3_m),
        .i_a3_2       (r_a3_w),
        .i_tnew_0     (2'd0),
        .i_tnew_1     (r_tnew_m),
        .i_tnew_2     (r_tnew_w),
        .o_sel        (fwd_rs_e),
        .o_match_tnew (w_rs_e_tnew_unused)
    );

    fwd_pick #(.EN(3'b110), .TNEW_EN(3'b000)) u_rt_e (
        .i_reg        (r_a2_e),
        .i_a3_0       (5'd0),
        .i_a3_1       (r_a3_m),
        .i_a3_2       (r_a3_w),
        .i_tnew_0     (2'd0),
        .i_tnew_1     (r_tnew_m),
        .i_tnew_2     (r_tnew_w),
        .o_sel        (fwd_rt_e),
        .o_match_tnew (w_rt_e_tnew_unused)
    );

    fwd_pick #(.EN(3'b100), .TNEW_EN(3'b000)) u_rt_m (
        .i_reg        (r_a2_m),
        .i_a3_0       (5'd0),
        .i_a3_1       (5'd0),
        .i_a3_2       (r_a3_w),
        .i_tnew_0     (2'd0),
        .i_tnew_1     (2'd0),
        .i_tnew_2     (r_tnew_w),
        .o_sel        (w_rt_m_sel),
        .o_match_tnew (w_rt_m_tnew_unused)
    );

    assign w_stall = (w_rs_used && (w_rs_tnew > w_rs_tuse))
                  || (w_rt_used && (w_rt_tnew > w_rt_tuse));

    assign stall     = w_stall;
    assign fwd_rt_m  = (w_rt_m_sel == FWD_W);
    assign stall_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a1_e   <= '0;
            r_a2_e   <= '0;
            r_a3_e   <= '0;
            r_tnew_e <= '0;
            r_a2_m   <= '0;
            r_a3_m   <= '0;
            r_tnew_m <= '0;
            r_a3_w   <= '0;
            r_tnew_w <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_stall) begin
                r_a1_e   <= '0;
                r_a2_e   <= '0;
                r_a3_e   <= '0;
                r_tnew_e <= '0;
            end else begin
                r_a1_e   <= a1_d;
                r_a2_e   <= a2_d;
                r_a3_e   <= a3_d;
                r_tnew_e <= w_tnew_d;
            end
            r_a2_m   <= r_a2_e;
            r_a3_m   <= r_a3_e;
            r_tnew_m <= dec_sat(r_tnew_e);
            r_a3_w   <= r_a3_m;
            r_tnew_w <= dec_sat(r_tnew_m);
            if (w_stall && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-cycle D stimulus with
// hand-derived expected stall/forward/count vectors.
module tb_hazard_ctrl;

    localparam int CW = 2;

    localparam logic [4:0] RS0 = 5'b10000;
    localparam logic [4:0] RS1 = 5'b01000;
    localparam logic [4:0] RT0 = 5'b00100;
    localparam logic [4:0] RT1 = 5'b00010;
    localparam logic [4:0] RT2 = 5'b00001;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tuse_rs0 = 1'b0, tuse_rs1 = 1'b0;
    logic          tuse_rt0 = 1'b0, tuse_rt1 = 1'b0, tuse_rt2 = 1'b0;
    logic [4:0]    a1_d = '0, a2_d = '0, a3_d = '0;
    logic [1:0]    res_d = '0;
    logic          stall;
    logic [1:0]    fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic          fwd_rt_m;
    logic [CW-1:0] stall_cnt;

    logic [11:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CW), .TNEW_ALU(1), .TNEW_DM(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .tuse_rs0  (tuse_rs0),
        .tuse_rs1  (tuse_rs1),
        .tuse_rt0  (tuse_rt0),
        .tuse_rt1  (tuse_rt1),
        .tuse_rt2  (tuse_rt2),
        .a1_d      (a1_d),
        .a2_d      (a2_d),
        .a3_d      (a3_d),
        .res_d     (res_d),
        .stall     (stall),
        .fwd_rs_d  (fwd_rs_d),
        .fwd_rt_d  (fwd_rt_d),
        .fwd_rs_e  (fwd_rs_e),
        .fwd_rt_e  (fwd_rt_e),
        .fwd_rt_m  (fwd_rt_m),
        .stall_cnt (stall_cnt)
    );

    wire [11:0] obs = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e,
                       fwd_rt_e, fwd_rt_m, stall_cnt};

    function automatic logic [21:0] ins(input logic [4:0] tu,
        input logic [4:0] a1, input logic [4:0] a2,
        input logic [4:0] a3, input logic [1:0] res);
        return {tu, a1, a2, a3, res};
    endfunction

    function automatic logic [11:0] ex(input logic s,
        input logic [1:0] rsd, input logic [1:0] rtd,
        input logic [1:0] rse, input logic [1:0] rte,
        input logic rtm, input logic [1:0] cnt);
        return {s, rsd, rtd, rse, rte, rtm, cnt};
    endfunction

    task automatic drive(input logic [21:0] v, input logic [11:0] e);
        {tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2} = v[21:17];
        a1_d  = v[16:12];
        a2_d  = v[11:7];
        a3_d  = v[6:2];
        res_d = v[1:0];
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        logic [11:0] want;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r = $urandom;
            if (i == 2) begin
                reset = 1'b1;
                drive(22'd0, ex(0, 0, 0, 0, 0, 0, 0));
            end else begin
                drive(r[21:0], ex(0, 0, 0, 0, 0, 0, 0));
            end
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL reset[%0d] got %03h want %03h", i, obs, want);
            end
        end
    endtask

    task automatic test_load_use();
        logic [21:0] s [7];
        logic [11:0] e [7];
        logic [11:0] want;
        s = '{ins(RS1, 0, 1, 1, 2'b10), ins(RS0 | RT0, 1, 1, 0, 0),
              ins(RS0 | RT0, 1, 1, 0, 0), ins(RS0 | RT0, 1, 1, 0, 0),
              22'd0, 22'd0, 22'd0};
        e = '{ex(0, 0, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0),
              ex(1, 0, 0, 0, 0, 0, 1), ex(0, 3, 3, 0, 0, 0, 2),
              ex(0, 0, 0, 0, 0, 0, 2), ex(0, 0, 0, 0, 0, 0, 2),
              ex(0, 0, 0, 0, 0, 0, 2)};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(s[i], e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL load_use[%0d] got %03h want %03h", i, obs, want);
            end
        end
    endtask

    task automatic test_alu_fwd();
        logic [21:0] s [6];
        logic [11:0] e [6];
        logic [11:0] want;
        s = '{ins(RS1 | RT1, 4, 5, 3, 2'b01), ins(RS1 | RT1, 3, 6, 7, 2'b01),
              ins(RS1 | RT1, 3, 0, 8, 2'b01), 22'd0, 22'd0, 22'd0};
        e = '{ex(0, 0, 0, 0, 0, 0, 2), ex(0, 0, 0, 0, 0, 0, 2),
              ex(0, 2, 0, 2, 0, 0, 2), ex(0, 0, 0, 3, 0, 0, 2),
              ex(0, 0, 0, 0, 0, 0, 2), ex(0, 0, 0, 0, 0, 0, 2)};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(s[i], e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL alu_fwd[%0d] got %03h want %03h", i, obs, want);
            end
        end
    endtask

    task automatic test_pc_fwd();
        logic [21:0] s [5];
        logic [11:0] e [5];
        logic [11:0] want;
        s = '{ins(0, 0, 0, 31, 2'b11), ins(RS0, 31, 0, 0, 0),
              22'd0, 22'd0, 22'd0};
        e = '{ex(0, 0, 0, 0, 0, 0, 2), ex(0, 1, 0, 0, 0, 0, 2),
              ex(0, 0, 0, 2, 0, 0, 2), ex(0, 0, 0, 0, 0, 0, 2),
              ex(0, 0, 0, 0, 0, 0, 2)};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(s[i], e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL pc_fwd[%0d] got %03h want %03h", i, obs, want);
            end
        end
    endtask

    task automatic test_zero_store();
        logic [21:0] s [7];
        logic [11:0] e [7];
        logic [11:0] want;
        s = '{ins(RS1, 0, 0, 0, 2'b10), ins(RS0 | RT0, 0, 0, 0, 0),
              ins(RS1, 0, 2, 2, 2'b10), ins(RS1 | RT2, 0, 2, 0, 0),
              22'd0, 22'd0, 22'd0};
        e = '{ex(0, 0, 0, 0, 0, 0, 2), ex(0, 0, 0, 0, 0, 0, 2),
              ex(0, 0, 0, 0, 0, 0, 2), ex(0, 0, 0, 0, 0, 0, 2),
              ex(0, 0, 0, 0, 0, 0, 2), ex(0, 0, 0, 0, 0, 1, 2),
              ex(0, 0, 0, 0, 0, 0, 2)};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(s[i], e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL zero_store[%0d] got %03h want %03h", i, obs, want);
            end
        end
    endtask

    task automatic test_sat_reset();
        logic [21:0] s [9];
        logic [11:0] e [9];
        logic        rs [9];
        logic [21:0] lw, beq;
        logic [11:0] want;
        lw  = ins(RS1, 0, 1, 1, 2'b10);
        beq = ins(RS0 | RT0, 1, 1, 0, 0);
        s  = '{lw, beq, beq, beq, lw, beq, beq, beq, 22'd0};
        rs = '{1, 1, 1, 1, 1, 1, 0, 1, 1};
        e  = '{ex(0, 0, 0, 0, 0, 0, 2), ex(1, 0, 0, 0, 0, 0, 2),
               ex(1, 0, 0, 0, 0, 0, 3), ex(0, 3, 3, 0, 0, 0, 3),
               ex(0, 0, 0, 0, 0, 0, 3), ex(1, 0, 0, 0, 0, 0, 3),
               ex(1, 0, 0, 0, 0, 0, 3), ex(0, 0, 0, 0, 0, 0, 0),
               ex(0, 0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            reset = rs[i];
            drive(s[i], e[i]);
            #1;
            want = sb.pop_front();
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL sat_reset[%0d] got %03h want %03h", i, obs, want);
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_pc_fwd();
        test_zero_store();
        test_sat_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
